// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a registered one-hot grant.
//
// A grant is held until the grantee strobes done. The requester after the
// grantee then has the highest priority for the next arbitration. Every
// release is followed by one idle cycle with gnt == 0, so grants are never
// back to back.
//
// Optional feature (macro GNT_TIMEOUT_EN): a grant-cycle counter forces a
// release after TIMEOUT cycles in GRANT without done, and pulses timeout for
// the idle cycle that follows. When the macro is undefined there is no
// counter and timeout is tied low.
//
// Parameters:
//   TIMEOUT    maximum GRANT cycles before a forced release (1..255)
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req[7:0]   request lines, bit i is requester i
//   done       grantee release strobe, only looked at while granting
//   gnt[7:0]   registered grant vector, all-zero or one-hot
//   gnt_valid  high when gnt is non-zero
//   timeout    forced-release pulse
module rr_arbiter8 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("rr_arbiter8: TIMEOUT must be in 1..255");
  end

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [2:0] idx_q;   // index of the current grantee
  logic [7:0] gnt_q;

  // Scan from ptr upward, modulo 8; the 3-bit add wraps naturally.
  logic       found;
  logic [2:0] sel_idx;
  logic [2:0] scan_idx;

  always_comb begin
    found    = 1'b0;
    sel_idx  = 3'd0;
    scan_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        sel_idx = scan_idx;
      end
    end
  end

`ifdef GNT_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       timeout_q;
  logic       expire;

  assign expire = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      idx_q     <= 3'd0;
      gnt_q     <= 8'd0;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found) begin
            gnt_q   <= 8'd1 << sel_idx;
            idx_q   <= sel_idx;
            cnt_q   <= 8'd0;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (done || expire) begin
            // done wins over a simultaneous expiry: normal release, no pulse.
            gnt_q     <= 8'd0;
            ptr_q     <= idx_q + 3'd1;
            state_q   <= StIdle;
            timeout_q <= !done;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      gnt_q   <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            gnt_q   <= 8'd1 << sel_idx;
            idx_q   <= sel_idx;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (done) begin
            gnt_q   <= 8'd0;
            ptr_q   <= idx_q + 3'd1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8. A driver applies directed and random
// stimulus on the falling edge and pushes the reference model's expected
// outputs into a queue; a monitor pops and compares after each rising edge.
module tb_rr_arbiter8;

  localparam int unsigned Timeout = 15;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter8 #(
    .TIMEOUT(Timeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the grant (-1 = nobody), whose turn is next,
  // and how long the owner has held the grant.
  int m_owner = -1;
  int m_next  = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;
`ifdef GNT_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  task automatic model_step(input bit r, input logic [7:0] rq, input bit d);
    exp_t e;
    if (r) begin
      m_owner = -1;
      m_next  = 0;
      m_held  = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && rq[(m_next + k) % 8]) begin
          m_owner = (m_next + k) % 8;
          m_held  = 1;
        end
      end
    end else if (d) begin
      m_next  = (m_owner + 1) % 8;
      m_owner = -1;
      m_to    = 1'b0;
    end else if (ToEn && m_held >= int'(Timeout)) begin
      m_next  = (m_owner + 1) % 8;
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
      m_to = 1'b0;
    end
    e.gnt   = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    e.valid = (m_owner >= 0);
    e.to    = m_to;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input logic [7:0] rq, input bit d);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    model_step(r, rq, d);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check8("gnt", gnt, mon_e.gnt);
      check8("gnt_valid", {7'd0, gnt_valid}, {7'd0, mon_e.valid});
      check8("timeout", {7'd0, timeout}, {7'd0, mon_e.to});
      check8("onehot0", {7'd0, $onehot0(gnt)}, 8'd1);
    end
  end

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset, then 05: grant 01, release, idle cycle, grant 04.
    repeat (2) drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h05, 1'b0);
    drive(1'b0, 8'h05, 1'b1);
    drive(1'b0, 8'h05, 1'b0);
    drive(1'b0, 8'h05, 1'b0);
    drive(1'b0, 8'h05, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // All requesting: full rotation 01..80 then wrap to 01.
    drive(1'b1, 8'h00, 1'b0);
    for (int g = 0; g < 9; g++) begin
      drive(1'b0, 8'hFF, 1'b0);
      drive(1'b0, 8'hFF, 1'b1);
    end

    // Requester 7 alone, pointer wraps to 0, then 81 picks 0.
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h80, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h81, 1'b0);
    drive(1'b0, 8'h81, 1'b1);

    // Reset mid-grant aborts without timeout; pointer back to 0.
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h10, 1'b0);
    drive(1'b0, 8'h10, 1'b0);
    drive(1'b1, 8'h10, 1'b0);
    drive(1'b0, 8'h30, 1'b0);
    drive(1'b0, 8'h30, 1'b0);
    drive(1'b0, 8'h30, 1'b1);

    // done held through idle is ignored, then releases immediately.
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h01, 1'b1);
    drive(1'b0, 8'h01, 1'b1);
    drive(1'b0, 8'h01, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Long grant without done: held forever, or forced release if enabled.
    drive(1'b1, 8'h00, 1'b0);
    repeat (40) drive(1'b0, 8'h06, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Random traffic with occasional resets and idle request patterns.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] rq;
      rq = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rq = 8'h00;
      drive(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) == 0));
    end
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);

    // Let the monitor drain, bounded.
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
